regfile_wb_scheduler: RTL and testbench

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

---
 rtl/regfile_wb_scheduler.sv | 108 ++++++++++
 tb/tb_regfile_wb_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: scoreboards pending destination registers,
// stalls hazardous issues and arbitrates the single RF write port between ALU and load unit.
module regfile_wb_scheduler #(
    parameter bit MEM_FIRST = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rd_we,
    output logic        issue_stall,
    input  logic        alu_wb_valid,
    input  logic [4:0]  alu_wb_rd,
    input  logic [31:0] alu_wb_data,
    output logic        alu_wb_ready,
    input  logic        mem_wb_valid,
    input  logic [4:0]  mem_wb_rd,
    input  logic [31:0] mem_wb_data,
    output logic        mem_wb_ready,
    output logic        rf_write_enable,
    output logic [4:0]  rf_addr_rd,
    output logic [31:0] rf_data_rd,
    output logic [5:0]  busy_count,
    output logic        idle,
    output logic        wb_error
);

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 6;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_set;
    logic [NREG-1:0] busy_clr;
    logic            prefer_mem;
    logic            conflict;
    logic            mem_win;
    logic            granted;
    logic            issue_accept;

    // Hazard check against the registered scoreboard only; no same-cycle bypass.
    always_comb begin
        issue_stall = 1'b0;
        if (!reset && issue_valid) begin
            issue_stall = busy[issue_rs1] || busy[issue_rs2] ||
                          (issue_rd_we && busy[issue_rd]);
        end
        issue_accept = !reset && issue_valid && !issue_stall;
    end

    // Write-port arbitration; prefer_mem flips only when both sides collide.
    always_comb begin
        conflict        = alu_wb_valid && mem_wb_valid;
        mem_win         = mem_wb_valid && (!alu_wb_valid || prefer_mem);
        alu_wb_ready    = !reset && alu_wb_valid && !mem_win;
        mem_wb_ready    = !reset && mem_win;
        granted         = alu_wb_ready || mem_wb_ready;
        rf_addr_rd      = AW'(0);
        rf_data_rd      = DW'(0);
        if (mem_wb_ready) begin
            rf_addr_rd = mem_wb_rd;
            rf_data_rd = mem_wb_data;
        end else if (alu_wb_ready) begin
            rf_addr_rd = alu_wb_rd;
            rf_data_rd = alu_wb_data;
        end
        rf_write_enable = granted && (rf_addr_rd != AW'(0));
    end

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (issue_accept && issue_rd_we && (issue_rd != AW'(0))) begin
            busy_set[issue_rd] = 1'b1;
        end
        if (rf_write_enable) begin
            busy_clr[rf_addr_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy       <= '0;
            prefer_mem <= MEM_FIRST;
            wb_error   <= 1'b0;
        end else begin
            busy       <= ((busy & ~busy_clr) | busy_set) & ~NREG'(1);
            if (conflict) begin
                prefer_mem <= !prefer_mem;
            end
            if (rf_write_enable && !busy[rf_addr_rd]) begin
                wb_error <= 1'b1;
            end
        end
    end

    always_comb begin
        busy_count = CW'(0);
        for (int i = 0; i < NREG; i++) begin
            busy_count = busy_count + CW'(busy[i]);
        end
        idle = (busy_count == CW'(0));
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: vector table plus a reset-in-flight sequence.
module tb_regfile_wb_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_rd_we;
    logic        issue_stall;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        alu_wb_ready;
    logic        mem_wb_valid;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_data;
    logic        mem_wb_ready;
    logic        rf_write_enable;
    logic [4:0]  rf_addr_rd;
    logic [31:0] rf_data_rd;
    logic [5:0]  busy_count;
    logic        idle;
    logic        wb_error;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    regfile_wb_scheduler #(.MEM_FIRST(1'b1)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_stall(issue_stall),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .alu_wb_ready(alu_wb_ready),
        .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
        .mem_wb_ready(mem_wb_ready),
        .rf_write_enable(rf_write_enable), .rf_addr_rd(rf_addr_rd), .rf_data_rd(rf_data_rd),
        .busy_count(busy_count), .idle(idle), .wb_error(wb_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned iv, rs1, rs2, rd, rwe;
        int unsigned av, ard, adat;
        int unsigned mv, mrd, mdat;
        int unsigned e_stall, e_ar, e_mr, e_we, e_addr, e_data, e_bc, e_err;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid  = 1'(v.iv);
        issue_rs1    = 5'(v.rs1);
        issue_rs2    = 5'(v.rs2);
        issue_rd     = 5'(v.rd);
        issue_rd_we  = 1'(v.rwe);
        alu_wb_valid = 1'(v.av);
        alu_wb_rd    = 5'(v.ard);
        alu_wb_data  = v.adat;
        mem_wb_valid = 1'(v.mv);
        mem_wb_rd    = 5'(v.mrd);
        mem_wb_data  = v.mdat;
    endtask

    task automatic check_all(input int idx, input vec_t v);
        chk("issue_stall", idx, 32'(issue_stall), v.e_stall);
        chk("alu_wb_ready", idx, 32'(alu_wb_ready), v.e_ar);
        chk("mem_wb_ready", idx, 32'(mem_wb_ready), v.e_mr);
        chk("rf_write_enable", idx, 32'(rf_write_enable), v.e_we);
        chk("rf_addr_rd", idx, 32'(rf_addr_rd), v.e_addr);
        chk("rf_data_rd", idx, 32'(rf_data_rd), v.e_data);
        chk("busy_count", idx, 32'(busy_count), v.e_bc);
        chk("idle", idx, 32'(idle), (v.e_bc == 0) ? 1 : 0);
        chk("wb_error", idx, 32'(wb_error), v.e_err);
    endtask

    initial begin
        //          iv rs1 rs2 rd rwe  av ard adat          mv mrd mdat          st ar mr we adr data          bc er
        vt[0]  = '{0, 0, 0, 0, 0,    0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0,            0, 0};
        vt[1]  = '{1, 0, 0, 5, 1,    0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0,            0, 0};
        vt[2]  = '{1, 5, 0, 6, 1,    0, 0, 0,             0, 0, 0,             1, 0, 0, 0, 0, 0,            1, 0};
        vt[3]  = '{1, 5, 0, 6, 1,    1, 5, 32'h12345678,  0, 0, 0,             1, 1, 0, 1, 5, 32'h12345678, 1, 0};
        vt[4]  = '{1, 5, 0, 6, 1,    0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0,            0, 0};
        vt[5]  = '{0, 0, 0, 0, 0,    0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0,            1, 0};
        vt[6]  = '{0, 0, 0, 0, 0,    1, 6, 32'h00000066,  0, 0, 0,             0, 1, 0, 1, 6, 32'h00000066, 1, 0};
        vt[7]  = '{1, 0, 0, 3, 1,    0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0,            0, 0};
        vt[8]  = '{1, 0, 0, 4, 1,    0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0,            1, 0};
        vt[9]  = '{0, 0, 0, 0, 0,    1, 3, 32'hAAAA0000,  1, 4, 32'h5555FFFF,  0, 0, 1, 1, 4, 32'h5555FFFF, 2, 0};
        vt[10] = '{0, 0, 0, 0, 0,    1, 3, 32'hAAAA0000,  0, 0, 0,             0, 1, 0, 1, 3, 32'hAAAA0000, 1, 0};
        vt[11] = '{0, 0, 0, 0, 0,    1, 0, 32'h00000001,  1, 0, 32'hFFFFFFFF,  0, 1, 0, 0, 0, 32'h00000001, 0, 0};
        vt[12] = '{0, 0, 0, 0, 0,    0, 0, 0,             1, 0, 32'hFFFFFFFF,  0, 0, 1, 0, 0, 32'hFFFFFFFF, 0, 0};
        vt[13] = '{0, 0, 0, 0, 0,    1, 0, 32'h00000003,  1, 0, 32'h00000004,  0, 0, 1, 0, 0, 32'h00000004, 0, 0};
        vt[14] = '{0, 0, 0, 0, 0,    1, 7, 32'hDEADBEEF,  0, 0, 0,             0, 1, 0, 1, 7, 32'hDEADBEEF, 0, 0};
        vt[15] = '{0, 0, 0, 0, 0,    0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0,            0, 1};
        vt[16] = '{1, 0, 0, 8, 1,    0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0,            0, 1};
        vt[17] = '{1, 0, 8, 9, 1,    0, 0, 0,             0, 0, 0,             1, 0, 0, 0, 0, 0,            1, 1};
        vt[18] = '{1, 0, 0, 8, 1,    0, 0, 0,             0, 0, 0,             1, 0, 0, 0, 0, 0,            1, 1};
        vt[19] = '{1, 0, 0, 8, 0,    0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0,            1, 1};
        vt[20] = '{0, 8, 8, 8, 1,    0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0,            1, 1};
        vt[21] = '{0, 0, 0, 0, 0,    0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0,            1, 1};

        reset = 1'b1;
        drive(vt[0]);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i]);
            #2;
            check_all(i, vt[i]);
            @(negedge clock);
        end

        // Build up busy regs 1, 2, 9 on top of the pending 8.
        for (int r = 0; r < 3; r++) begin
            issue_valid = 1'b1; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd_we = 1'b1;
            issue_rd = (r == 0) ? 5'd1 : (r == 1) ? 5'd2 : 5'd9;
            @(negedge clock);
        end
        issue_valid = 1'b0;
        #2;
        chk("busy_count_pre_reset", 100, 32'(busy_count), 4);

        // Reset with requests in flight: everything forced quiet combinationally.
        @(negedge clock);
        reset = 1'b1;
        issue_valid = 1'b1; issue_rs1 = 5'd9; issue_rd_we = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd1; alu_wb_data = 32'h11;
        mem_wb_valid = 1'b1; mem_wb_rd = 5'd2; mem_wb_data = 32'h22;
        #2;
        chk("stall_in_reset", 101, 32'(issue_stall), 0);
        chk("alu_ready_in_reset", 101, 32'(alu_wb_ready), 0);
        chk("mem_ready_in_reset", 101, 32'(mem_wb_ready), 0);
        chk("rf_we_in_reset", 101, 32'(rf_write_enable), 0);
        @(negedge clock);
        reset = 1'b0;
        alu_wb_valid = 1'b0; mem_wb_valid = 1'b0;
        #2;
        chk("busy_count_post_reset", 102, 32'(busy_count), 0);
        chk("idle_post_reset", 102, 32'(idle), 1);
        chk("wb_error_post_reset", 102, 32'(wb_error), 0);
        chk("rf_addr_post_reset", 102, 32'(rf_addr_rd), 0);
        chk("rf_data_post_reset", 102, 32'(rf_data_rd), 0);
        chk("stall_rs9_post_reset", 102, 32'(issue_stall), 0);

        // Alternation state restarts at MEM_FIRST after reset.
        @(negedge clock);
        issue_valid = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'hA1;
        mem_wb_valid = 1'b1; mem_wb_rd = 5'd0; mem_wb_data = 32'hB2;
        #2;
        chk("first_conflict_mem", 103, 32'(mem_wb_ready), 1);
        chk("first_conflict_alu", 103, 32'(alu_wb_ready), 0);
        chk("first_conflict_data", 103, rf_data_rd, 32'hB2);
        @(negedge clock);
        alu_wb_valid = 1'b0; mem_wb_valid = 1'b0;
        #2;
        chk("wb_error_rd0_only", 104, 32'(wb_error), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
